pila_retorno: RTL and testbench

PILA_RETORNO -- requirements
Module: pila_retorno

---
 rtl/pila_retorno.sv | 87 ++++++++
 tb/tb_pila_retorno.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pila_retorno.sv
// Return-address stack (LIFO) with combinational top-of-stack output.
// Optional sticky overflow/underflow flags are enabled by defining PILA_RETORNO_ERR_EN.
module pila_retorno #(
   parameter  int WIDTH = 10,
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   logic [WIDTH-1:0] entry [DEPTH];
   logic [CW-1:0]    sp;
   logic [PW-1:0]    top_idx;
   logic [PW-1:0]    wr_idx;
   logic             do_push;
   logic             do_pop;
   logic             do_replace;
   logic             wr_en;
   logic             ovf_evt;
   logic             unf_evt;

   assign empty = (sp == '0);
   assign full  = (sp == CW'(DEPTH));
   assign count = sp;

   // Push+pop on a non-empty stack rewrites the top in place; on an empty stack it is a plain push.
   always_comb begin
      top_idx    = PW'(sp - CW'(1));
      do_replace = push & pop & ~empty;
      do_push    = push & ~do_replace & ~full;
      do_pop     = pop & ~push & ~empty;
      ovf_evt    = push & ~pop & full;
      unf_evt    = pop & ~push & empty;
      wr_en      = (do_push | do_replace) & ~reset;
      wr_idx     = do_replace ? top_idx : sp[PW-1:0];
   end

   // Array is never cleared; entries above sp are unreachable because q is masked when empty.
   always_ff @(posedge clk) begin
      if (wr_en)
         entry[wr_idx] <= d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sp <= '0;
      else if (do_push)
         sp <= sp + CW'(1);
      else if (do_pop)
         sp <= sp - CW'(1);
   end

   assign q = empty ? '0 : entry[top_idx];

`ifdef PILA_RETORNO_ERR_EN
   // Sticky error flags; only reset clears them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (ovf_evt)
            ovf <= 1'b1;
         if (unf_evt)
            unf <= 1'b1;
      end
   end
`else
   assign ovf = 1'b0;
   assign unf = 1'b0;

   logic unused_evt;
   assign unused_evt = ovf_evt ^ unf_evt;
`endif

endmodule

// File: tb/tb_pila_retorno.sv
// Scoreboard bench for pila_retorno: a queue-based LIFO model predicts every cycle,
// monitors compare DUT outputs (DEPTH=8/WIDTH=10 and DEPTH=2/WIDTH=16 instances).
module tb_pila_retorno;

   typedef struct {
      logic [15:0] q;
      logic [6:0]  count;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        push8 = 1'b0, pop8 = 1'b0;
   logic [9:0]  d8 = '0;
   logic [9:0]  q8;
   logic [3:0]  count8;
   logic        empty8, full8, ovf8, unf8;

   logic        push2 = 1'b0, pop2 = 1'b0;
   logic [15:0] d2 = '0;
   logic [15:0] q2;
   logic [1:0]  count2;
   logic        empty2, full2, ovf2, unf2;

   int checks = 0;
   int errors = 0;

   exp_t        sb8[$];
   exp_t        sb2[$];
   logic [15:0] model8[$];
   logic [15:0] model2[$];
   logic        ovf8m = 1'b0, unf8m = 1'b0;
   logic        ovf2m = 1'b0, unf2m = 1'b0;

   pila_retorno #(.WIDTH(10), .DEPTH(8)) dut8 (
      .clk(clk), .reset(reset), .push(push8), .pop(pop8), .d(d8),
      .q(q8), .count(count8), .empty(empty8), .full(full8), .ovf(ovf8), .unf(unf8)
   );

   pila_retorno #(.WIDTH(16), .DEPTH(2)) dut2 (
      .clk(clk), .reset(reset), .push(push2), .pop(pop2), .d(d2),
      .q(q2), .count(count2), .empty(empty2), .full(full2), .ovf(ovf2), .unf(unf2)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // LIFO rules applied to a queue; the error flags only exist in the macro build.
   task automatic modelStep(inout logic [15:0] m[$], input int depth, input bit p, input bit o,
                            input logic [15:0] v, inout logic of, inout logic uf, output exp_t e);
      if (p && o && m.size() > 0)
         m[m.size()-1] = v;
      else if (p) begin
         if (m.size() < depth) m.push_back(v);
         else of = 1'b1;
      end else if (o) begin
         if (m.size() > 0) void'(m.pop_back());
         else uf = 1'b1;
      end
      e.q     = (m.size() == 0) ? 16'h0 : m[m.size()-1];
      e.count = 7'(m.size());
      e.empty = (m.size() == 0);
      e.full  = (m.size() == depth);
`ifdef PILA_RETORNO_ERR_EN
      e.ovf   = of;
      e.unf   = uf;
`else
      e.ovf   = 1'b0;
      e.unf   = 1'b0;
`endif
   endtask

   // Called just after a falling edge: drive one operation and predict the post-edge state.
   task automatic applyStimulus8(input bit p, input bit o, input logic [9:0] v);
      exp_t e;
      push8 = p; pop8 = o; d8 = v;
      modelStep(model8, 8, p, o, {6'b0, v}, ovf8m, unf8m, e);
      sb8.push_back(e);
      @(negedge clk);
   endtask

   task automatic applyStimulus2(input bit p, input bit o, input logic [15:0] v);
      exp_t e;
      push2 = p; pop2 = o; d2 = v;
      modelStep(model2, 2, p, o, v, ovf2m, unf2m, e);
      sb2.push_back(e);
      @(negedge clk);
   endtask

   // Reset is raised between edges and must take effect before the next rising edge.
   task automatic applyReset();
      exp_t e;
      reset = 1'b1;
      push8 = 1'b1; pop8 = 1'b0; d8 = 10'h3C3;
      push2 = 1'b0; pop2 = 1'b0;
      #1;
      checkOutput("rst_count", 32'(count8), 32'd0);
      checkOutput("rst_q",     32'(q8),     32'd0);
      checkOutput("rst_empty", 32'(empty8), 32'd1);
      checkOutput("rst_full",  32'(full8),  32'd0);
      checkOutput("rst_ovf",   32'(ovf8),   32'd0);
      checkOutput("rst_unf",   32'(unf8),   32'd0);
      checkOutput("rst_count2", 32'(count2), 32'd0);
      model8.delete(); model2.delete();
      ovf8m = 1'b0; unf8m = 1'b0; ovf2m = 1'b0; unf2m = 1'b0;
      e.q = '0; e.count = '0; e.empty = 1'b1; e.full = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
      sb8.push_back(e);
      @(negedge clk);
      reset = 1'b0;
      push8 = 1'b0;
   endtask

   initial begin : mon8
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb8.size() > 0) begin
            e = sb8.pop_front();
            checkOutput("q8",     32'(q8),     32'(e.q));
            checkOutput("count8", 32'(count8), 32'(e.count));
            checkOutput("empty8", 32'(empty8), 32'(e.empty));
            checkOutput("full8",  32'(full8),  32'(e.full));
            checkOutput("ovf8",   32'(ovf8),   32'(e.ovf));
            checkOutput("unf8",   32'(unf8),   32'(e.unf));
         end
      end
   end

   initial begin : mon2
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb2.size() > 0) begin
            e = sb2.pop_front();
            checkOutput("q2",     32'(q2),     32'(e.q));
            checkOutput("count2", 32'(count2), 32'(e.count));
            checkOutput("empty2", 32'(empty2), 32'(e.empty));
            checkOutput("full2",  32'(full2),  32'(e.full));
            checkOutput("ovf2",   32'(ovf2),   32'(e.ovf));
            checkOutput("unf2",   32'(unf2),   32'(e.unf));
         end
      end
   end

   initial begin : stim
      @(negedge clk);
      applyReset();

      // Basic push/pop ordering, then underflow and push+pop on empty.
      applyStimulus8(1, 0, 10'h001);
      applyStimulus8(1, 0, 10'h002);
      applyStimulus8(1, 0, 10'h003);
      applyStimulus8(0, 0, 10'h000);
      applyStimulus8(0, 1, 10'h000);
      applyStimulus8(0, 1, 10'h000);
      applyStimulus8(0, 1, 10'h000);
      applyStimulus8(0, 1, 10'h000);
      applyStimulus8(1, 1, 10'h155);

      // Fill to full, replace top while full, then overflow.
      applyReset();
      for (int i = 0; i < 8; i++)
         applyStimulus8(1, 0, 10'(16 + i));
      applyStimulus8(1, 1, 10'h2AA);
      applyStimulus8(1, 0, 10'h3FF);
      applyStimulus8(0, 1, 10'h000);

      // Reset in the middle of operation, then first push after release.
      applyReset();
      applyStimulus8(1, 0, 10'h0AB);
      applyStimulus8(1, 0, 10'h0CD);
      applyReset();
      applyStimulus8(1, 0, 10'h0EF);

      for (int i = 0; i < 300; i++)
         applyStimulus8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
      push8 = 1'b0; pop8 = 1'b0;

      applyReset();
      for (int i = 0; i < 400; i++)
         applyStimulus2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      push2 = 1'b0; pop2 = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("sb_drain", 32'(sb8.size() + sb2.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
